// File: rtl/riscv_imm_pkg.sv
// Opcode constants, immediate-format codes, skid-buffer states and the XLEN legality check
// shared by the immediate generator stage.
package riscv_imm_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // FmtZ stays reserved even when CSR-immediate decoding is compiled out.
  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtZ    = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

  localparam int unsigned XlenNarrow = 32;
  localparam int unsigned XlenWide   = 64;

  function automatic bit xlen_is_legal(input int unsigned xlen);
    return (xlen == XlenNarrow) || (xlen == XlenWide);
  endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational RV32I/RV64I immediate decoder: selects the format by opcode and sign-extends
// to XLEN. Macro IMM_GEN_STAGE_ZICSR_EN enables the zero-extended CSR-immediate (FmtZ) format.
module imm_fmt_decode
  import riscv_imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic [6:0]         opcode;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign opcode = instr_i[6:0];
  assign imm_i  = instr_i[31:20];
  assign imm_s  = {instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Every known opcode ends in 2'b11, so a compressed encoding falls into the default arm.
  always_comb begin
    imm_o     = '0;
    fmt_o     = FmtNone;
    illegal_o = 1'b0;
    case (opcode)
      OpLoad, OpImm, OpJalr: begin
        fmt_o = FmtI;
        imm_o = XLEN'(imm_i);
      end
      OpStore: begin
        fmt_o = FmtS;
        imm_o = XLEN'(imm_s);
      end
      OpBranch: begin
        fmt_o = FmtB;
        imm_o = XLEN'(imm_b);
      end
      OpLui, OpAuipc: begin
        fmt_o = FmtU;
        imm_o = XLEN'(imm_u);
      end
      OpJal: begin
        fmt_o = FmtJ;
        imm_o = XLEN'(imm_j);
      end
      OpReg, OpFence: begin
        fmt_o = FmtNone;
      end
      OpSystem: begin
`ifdef IMM_GEN_STAGE_ZICSR_EN
        if (instr_i[14]) begin
          fmt_o = FmtZ;
          imm_o = XLEN'(instr_i[19:15]);
        end
`else
        fmt_o = FmtNone;
`endif
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: registered output plus skid entry behind a valid/ready
// handshake. Optional CSR-immediate decoding is enabled by macro IMM_GEN_STAGE_ZICSR_EN.
module imm_gen_stage
  import riscv_imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (!xlen_is_legal(XLEN)) begin : g_xlen_check
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_fmt_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  skid_state_e      state_q, state_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  imm_fmt_e         out_fmt_q, out_fmt_d, skid_fmt_q, skid_fmt_d;
  logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic             accept, pop;

  // in_ready looks only at registered state, never at out_ready.
  assign in_ready    = !rst && !flush && (state_q != StTwo);
  assign out_valid   = (state_q != StEmpty);
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    out_ill_d  = out_ill_q;
    out_tag_d  = out_tag_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    skid_tag_d = skid_tag_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StOne;
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_ill_d = dec_illegal;
          out_tag_d = in_tag;
        end
      end
      StOne: begin
        if (accept && !pop) begin
          state_d    = StTwo;
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_ill_d = dec_illegal;
          skid_tag_d = in_tag;
        end else if (accept) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_ill_d = dec_illegal;
          out_tag_d = in_tag;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          state_d   = StOne;
          out_imm_d = skid_imm_q;
          out_fmt_d = skid_fmt_q;
          out_ill_d = skid_ill_q;
          out_tag_d = skid_tag_q;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_imm_q  <= '0;
      out_fmt_q  <= FmtNone;
      out_ill_q  <= 1'b0;
      out_tag_q  <= '0;
      skid_imm_q <= '0;
      skid_fmt_q <= FmtNone;
      skid_ill_q <= 1'b0;
      skid_tag_q <= '0;
    end else begin
      out_imm_q  <= out_imm_d;
      out_fmt_q  <= out_fmt_d;
      out_ill_q  <= out_ill_d;
      out_tag_q  <= out_tag_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
      skid_ill_q <= skid_ill_d;
      skid_tag_q <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are compared against a queue-based reference model.
module tb_imm_gen_stage;

  localparam int unsigned TagW = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [31:0]     in_instr;
  logic [TagW-1:0] in_tag;

  logic            rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0]     imm32;
  logic [63:0]     imm64;
  logic [2:0]      fmt32, fmt64;
  logic [TagW-1:0] tag32, tag64;

  typedef struct {
    logic [31:0]     instr;
    logic [TagW-1:0] tag;
  } entry_t;

  entry_t          q[$];
  logic [TagW-1:0] popped[$];
  int              errors = 0;
  int              checks = 0;
  bit              known  = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(TagW)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TagW)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference decode straight from the format rules, done on a 64-bit sign-extended word.
  function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] imm,
                                     output logic [2:0] fmt, output logic ill);
    longint s;
    s   = longint'($signed(ins));
    imm = '0;
    fmt = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin fmt = 3'd1; imm = s >>> 20; end
      7'h23: begin fmt = 3'd2; imm = ((s >>> 25) << 5) | longint'(ins[11:7]); end
      7'h63: begin
        fmt = 3'd3;
        imm = ((s >>> 31) << 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5)
            | (longint'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin fmt = 3'd4; imm = s & ~64'hFFF; end
      7'h6F: begin
        fmt = 3'd5;
        imm = ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11)
            | (longint'(ins[30:21]) << 1);
      end
      7'h33, 7'h0F: ;
      7'h73: begin
`ifdef IMM_GEN_STAGE_ZICSR_EN
        if (ins[14]) begin fmt = 3'd6; imm = 64'(ins[19:15]); end
`endif
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // One clock: settle, compare against the model, advance the model, step past the edge.
  task automatic cycle();
    bit          exp_ready, acc, pop;
    logic [63:0] eimm;
    logic [2:0]  efmt;
    logic        eill;
    #1;
    exp_ready = !rst && !flush && (q.size() < 2);
    check("in_ready32", 64'(rdy32), 64'(exp_ready));
    check("in_ready64", 64'(rdy64), 64'(exp_ready));
    if (known) begin
      check("out_valid32", 64'(vld32), 64'(q.size() != 0));
      check("out_valid64", 64'(vld64), 64'(q.size() != 0));
      if (q.size() != 0) begin
        ref_decode(q[0].instr, eimm, efmt, eill);
        check("imm32", 64'(imm32), 64'(eimm[31:0]));
        check("imm64", imm64, eimm);
        check("fmt32", 64'(fmt32), 64'(efmt));
        check("fmt64", 64'(fmt64), 64'(efmt));
        check("illegal32", 64'(ill32), 64'(eill));
        check("illegal64", 64'(ill64), 64'(eill));
        check("tag32", 64'(tag32), 64'(q[0].tag));
        check("tag64", 64'(tag64), 64'(q[0].tag));
      end
    end
    acc = in_valid && exp_ready;
    pop = (q.size() != 0) && out_ready;
    if (vld32 === 1'b1 && out_ready && !rst && !flush) popped.push_back(tag32);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{instr: in_instr, tag: in_tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [31:0] ins, input logic [63:0] e64,
                          input logic [2:0] efmt, input logic eill);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_tag    = $urandom;
    out_ready = 1'b1;
    flush     = 1'b0;
    cycle();
    in_valid = 1'b0;
    #1;
    check({name, "_vld"}, 64'(vld32), 64'd1);
    check({name, "_imm32"}, 64'(imm32), 64'(e64[31:0]));
    check({name, "_imm64"}, imm64, e64);
    check({name, "_fmt"}, 64'(fmt32), 64'(efmt));
    check({name, "_ill"}, 64'(ill32), 64'(eill));
    cycle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
                             7'h0F, 7'h73};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 10)]};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    cycle();
    known = 1;
    rst   = 1'b0;
    check("rst_valid", 64'(vld32), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    check("rst_fmt", 64'(fmt32), 64'd0);
    check("rst_ill", 64'(ill64), 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    cycle();

    directed("lw",   32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
    directed("sw",   32'h00312423, 64'h0000_0000_0000_0008, 3'd2, 1'b0);
    directed("beq",  32'hFE0008E3, 64'hFFFF_FFFF_FFFF_FFF0, 3'd3, 1'b0);
    directed("lui",  32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    directed("ill",  32'h0000007F, 64'h0,                   3'd0, 1'b1);
`ifdef IMM_GEN_STAGE_ZICSR_EN
    directed("csri", 32'h3401D073, 64'h3,                   3'd6, 1'b0);
`else
    directed("csri", 32'h3401D073, 64'h0,                   3'd0, 1'b0);
`endif

    // Back-pressure: third offer must stall, then all three drain in order.
    popped.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = rand_instr();
    in_tag = 1; cycle();
    in_tag = 2; cycle();
    in_tag = 3;
    #1;
    check("bp_ready_drop", 64'(rdy32), 64'd0);
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    check("bp_count", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++) check("bp_order", 64'(popped[i]), 64'(i + 1));

    // Flush while full with a simultaneous offer: everything disappears.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 4; cycle();
    in_tag = 5; cycle();
    popped.delete();
    flush = 1'b1; in_tag = 6; cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_empty", 64'(vld32), 64'd0);
    out_ready = 1'b1;
    cycle();
    cycle();
    check("flush_drop", 64'(popped.size()), 64'd0);

    // Reset (with flush) mid-operation clears both entries and the output registers.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 7; cycle();
    in_tag = 8; cycle();
    rst = 1'b1; flush = 1'b1; cycle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rst_mid_valid", 64'(vld64), 64'd0);
    check("rst_mid_tag", 64'(tag64), 64'd0);
    check("rst_mid_imm", 64'(imm32), 64'd0);
    cycle();

    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 31) == 0;
      in_instr  = rand_instr();
      in_tag    = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
